// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide, one bit per clock, start/busy/done handshake.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic                 neg_res;
    logic                 neg_rem;
    logic                 is_div;
    logic                 dz;

    logic                 is_signed;
    logic [WIDTH-1:0]     abs1;
    logic [WIDTH-1:0]     abs2;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    // acc holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        abs1      = (is_signed && operand1[WIDTH-1]) ? -operand1 : operand1;
        abs2      = (is_signed && operand2[WIDTH-1]) ? -operand2 : operand2;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opb};
        div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opb}) : div_shift[WIDTH-1:0];
        prod_fix  = neg_res ? -acc : acc;
        quo_fix   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            opa         <= '0;
            opb         <= '0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            is_div      <= 1'b0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                div_by_zero <= 1'b0;
                                busy        <= 1'b1;
                                cnt         <= CNT_W'(WIDTH);
                                opa         <= operand1;
                                opb         <= abs2;
                                acc         <= {{WIDTH{1'b0}}, abs1};
                                neg_res     <= is_signed && (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
                                neg_rem     <= is_signed && operand1[WIDTH-1];
                                is_div      <= op[1];
                                dz          <= (operand2 == '0);
                                state       <= op[1] ? DIV : MUL;
                            end
                            OP_MTHI: begin
                                hi          <= operand1;
                                done        <= 1'b1;
                                div_by_zero <= 1'b0;
                            end
                            OP_MTLO: begin
                                lo          <= operand1;
                                done        <= 1'b1;
                                div_by_zero <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= FIX;
                end
                DIV: begin
                    acc <= {div_rem, acc[WIDTH-2:0], div_ge};
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= FIX;
                end
                FIX: begin
                    // divide-by-zero bypasses the datapath result entirely
                    if (is_div) begin
                        hi          <= dz ? opa : rem_fix;
                        lo          <= dz ? {WIDTH{1'b1}} : quo_fix;
                        div_by_zero <= dz;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: multiply, divide, HI/LO moves,
// handshake timing, ignored starts, mid-operation reset and invalid opcodes.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;
    int lat;
    int busyCycles;
    int donePulses;

    muldiv_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand1    (operand1),
        .operand2    (operand2),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Presents a request for exactly one rising edge (edge 0)
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        op       = o;
        operand1 = a;
        operand2 = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    // lat is the edge count until done is seen (0 if it never shows up)
    task automatic waitDone(output int latency, output int busyCnt);
        latency = 0;
        busyCnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                latency = i;
                break;
            end
            if (busy) busyCnt++;
        end
    endtask

    task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] expHiLo, input logic expDz);
        applyStimulus(o, a, b);
        waitDone(lat, busyCycles);
        checkOutput({tag, "_latency"}, 64'(lat), 64'd33);
        checkOutput({tag, "_hilo"}, {hi, lo}, expHiLo);
        checkOutput({tag, "_dz"}, 64'(div_by_zero), 64'(expDz));
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        op       = 3'b000;
        operand1 = '0;
        operand2 = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        checkOutput("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;

        // MULTU 3x2 with full handshake timing checks
        applyStimulus(3'b001, 32'd3, 32'd2);
        checkOutput("multu_busy_after_accept", 64'(busy), 64'd1);
        checkOutput("multu_hilo_held", {hi, lo}, 64'd0);
        waitDone(lat, busyCycles);
        checkOutput("multu_latency", 64'(lat), 64'd33);
        checkOutput("multu_busy_cycles", 64'(busyCycles), 64'd32);
        checkOutput("multu_busy_at_done", 64'(busy), 64'd0);
        checkOutput("multu_hilo", {hi, lo}, 64'h00000000_00000006);
        @(posedge clk);
        #1;
        checkOutput("multu_done_one_cycle", 64'(done), 64'd0);

        runOp("mult_neg", 3'b000, 32'hFFFFFFFD, 32'd2, 64'hFFFFFFFF_FFFFFFFA, 1'b0);
        runOp("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
        runOp("mult_minmin", 3'b000, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0);
        runOp("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
        runOp("div_negdivisor", 3'b010, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0);
        runOp("divu", 3'b011, 32'd7, 32'd2, 64'h00000001_00000003, 1'b0);
        runOp("div_overflow", 3'b010, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
        runOp("divu_zero", 3'b011, 32'd7, 32'd0, 64'h00000007_FFFFFFFF, 1'b1);

        // MTLO right after a divide-by-zero clears the flag and leaves HI alone
        applyStimulus(3'b101, 32'd5, 32'd0);
        checkOutput("mtlo_done", {62'd0, done, busy}, 64'h2);
        checkOutput("mtlo_hilo", {hi, lo}, 64'h00000007_00000005);
        checkOutput("mtlo_dz_cleared", 64'(div_by_zero), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("mtlo_done_one_cycle", 64'(done), 64'd0);

        runOp("div_neg_zero", 3'b010, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, 1'b1);

        // MULT with a DIV start attempted at edge 10 and operands changed mid-flight
        applyStimulus(3'b000, 32'd6, 32'hFFFFFFF9);
        operand1 = 32'd100;
        operand2 = 32'd3;
        op       = 3'b011;
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 3'b010;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(lat, busyCycles);
        checkOutput("ignored_start_latency", 64'(lat), 64'd23);
        checkOutput("ignored_start_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFD6);

        // Back-to-back start in the done cycle
        applyStimulus(3'b011, 32'd100, 32'd7);
        checkOutput("b2b_accept_busy", 64'(busy), 64'd1);
        waitDone(lat, busyCycles);
        checkOutput("b2b_latency", 64'(lat), 64'd33);
        checkOutput("b2b_hilo", {hi, lo}, 64'h00000002_0000000E);

        // Reset asserted at edge 15 of a MULT aborts it
        applyStimulus(3'b000, 32'd5, 32'd5);
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        checkOutput("midreset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        donePulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) donePulses++;
        end
        checkOutput("midreset_no_done", 64'(donePulses), 64'd0);

        // Invalid opcode is ignored entirely
        applyStimulus(3'b100, 32'h00001234, 32'd0);
        checkOutput("mthi_hilo", {hi, lo}, 64'h00001234_00000000);
        @(posedge clk);
        #1;
        applyStimulus(3'b111, 32'd9, 32'd3);
        checkOutput("invalid_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        donePulses = 0;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) donePulses++;
        end
        checkOutput("invalid_no_response", 64'(donePulses), 64'd0);
        checkOutput("invalid_hilo", {hi, lo}, 64'h00001234_00000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit that extends the single-cycle ALU with MIPS-style MULT/MULTU/DIV/DIVU and HI/LO register semantics. It processes one bit per cycle under a start/busy/done handshake and holds results in internal HI/LO registers. It sits beside the combinational ALU in the execute stage and stalls the core while busy.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO (must be ≥4)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only on a rising edge where busy=0 and op is valid
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 invalid
operand1  input  WIDTH  multiplicand / dividend / MTHI-MTLO source
operand2  input  WIDTH  multiplier / divisor
busy  output  1  high while a multiply or divide is in flight
done  output  1  one-cycle pulse when a result has been written
div_by_zero  output  1  set with done for DIV/DIVU when operand2=0; cleared on the next accepted start
hi  output  WIDTH  HI register (product upper half / remainder)
lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset: state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0. Reset during a multiply or divide aborts it without writing a result.
- States: IDLE, MUL, DIV, FIX.
- IDLE: on accept edge (edge 0), operands are latched. Signed ops latch absolute values and record the result signs. Counter is set to WIDTH. MULT/MULTU go to MUL; DIV/DIVU go to DIV; busy=1.
- MTHI/MTLO: written at edge 0. done pulses for the following cycle; busy stays 0; state stays IDLE.
- Invalid op, or start while busy: ignored, with no state change.
- MUL: shift-add, one multiplier bit per edge, edges 1..WIDTH; uses a 2*WIDTH-bit accumulator.
- DIV: restoring division, one quotient bit per edge, edges 1..WIDTH.
- After WIDTH iterations, go to FIX. On edge WIDTH+1:
  - apply sign correction;
  - write hi/lo;
  - done=1, busy=0;
  - return to IDLE.
- Result latency: WIDTH+1 edges after accept (33 for default), with done high for exactly that one cycle.
- hi/lo hold their previous values for the whole operation; they update only on the FIX edge or on MTHI/MTLO.
- A new start may be accepted in the same cycle that done is high, since busy=0.
- MULT: signed 2*WIDTH product; hi=upper half, lo=lower half. MULTU: unsigned product.
- DIV: quotient truncates toward zero; remainder takes the sign of the dividend. DIVU: unsigned.
- Signed overflow (most-negative / -1): lo=most-negative value (wraps), hi=0; div_by_zero=0.
- Divide by zero (DIV or DIVU): same latency; hi=operand1 as latched, lo=all ones; div_by_zero=1 with done.
- operand1/operand2/op changes after the accept edge have no effect on the in-flight operation.

Test Plan:
- Reset, then MULTU 3×2, start held 1 cycle → done at edge 33; hi=0x00000000, lo=0x00000006; busy high for edges 1..32.
- MULT -3×2 → hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0.
- DIVU 7/0 → done at edge 33, div_by_zero=1, hi=7, lo=0xFFFFFFFF. Following MTLO 5 → lo=5, done next cycle, busy=0, div_by_zero=0.
- Start a MULT. Assert start with a DIV at edge 10 → ignored; original product returned at edge 33. Back-to-back start on the done cycle → accepted.
- MULT in flight, assert reset at edge 15 → outputs 0 next cycle and no done pulse. Op=111 with start → no response.
